// File: rtl/window_register_file_pkg.sv
// Shared constants for the windowed SPARC integer register file: register
// counts per window and the physical storage depth derived from NWINDOWS.
package window_register_file_pkg;

  localparam int NUM_GLOBALS = 8;
  localparam int WIN_SIZE    = 16;

  // Physical words needed for the globals plus NWINDOWS overlapping windows.
  function automatic int phys_depth(input int nwindows);
    return NUM_GLOBALS + WIN_SIZE * nwindows;
  endfunction

endpackage

// File: rtl/window_register_file_addr_map.sv
// Logical-to-physical register index mapping for one address and window.
// Outs and locals of window w are contiguous; ins alias the outs of w+1.
module window_addr_map
  import window_register_file_pkg::*;
#(
  parameter int NWINDOWS = 4,
  parameter int PW       = 7
) (
  input  logic [4:0]    addr,
  input  logic [2:0]    win,
  output logic [PW-1:0] phys
);

  logic [2:0] win_next;
  int         idx;

  always_comb begin
    win_next = (win == 3'(NWINDOWS - 1)) ? 3'd0 : win + 3'd1;
    idx      = 0;
    if (addr < 5'd8) begin
      idx = int'(addr);
    end else if (addr < 5'd24) begin
      // r8..r23 share one formula: outs at 8+16w, locals follow directly.
      idx = NUM_GLOBALS + WIN_SIZE * int'(win) + int'(addr) - 8;
    end else begin
      idx = NUM_GLOBALS + WIN_SIZE * int'(win_next) + int'(addr) - 24;
    end
    phys = PW'(idx);
  end

endmodule

// File: rtl/window_register_file.sv
// Windowed SPARC register file: storage, CWP, SAVE/RESTORE trap pulses.
// Optional same-cycle write-to-read bypass enabled by defining WRF_BYPASS_EN.
module window_register_file
  import window_register_file_pkg::*;
#(
  parameter int NWINDOWS = 4,
  parameter int WIDTH    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          ra_addr,
  input  logic [4:0]          rb_addr,
  output logic [WIDTH-1:0]    ra_data,
  output logic [WIDTH-1:0]    rb_data,
  input  logic                wr_en,
  input  logic [4:0]          wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                save,
  input  logic                restore,
  input  logic [NWINDOWS-1:0] wim,
  output logic [2:0]          cwp,
  output logic                win_overflow,
  output logic                win_underflow
);

  localparam int DEPTH = phys_depth(NWINDOWS);
  localparam int PW    = $clog2(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [2:0]       cwp_q;
  logic [2:0]       save_tgt;
  logic [2:0]       restore_tgt;
  logic [2:0]       wr_win;
  logic             save_only;
  logic             restore_only;
  logic             save_tgt_invalid;
  logic             restore_tgt_invalid;
  logic             overflow;
  logic             underflow;
  logic             wr_ok;
  logic [PW-1:0]    ra_phys;
  logic [PW-1:0]    rb_phys;
  logic [PW-1:0]    wr_phys;

  // Simultaneous save and restore is illegal and behaves as neither.
  assign save_only    = save & ~restore;
  assign restore_only = restore & ~save;

  assign save_tgt    = (cwp_q == 3'd0) ? 3'(NWINDOWS - 1) : cwp_q - 3'd1;
  assign restore_tgt = (cwp_q == 3'(NWINDOWS - 1)) ? 3'd0 : cwp_q + 3'd1;

  // Looked up by comparison so the 3-bit window index never over-selects wim.
  always_comb begin
    save_tgt_invalid    = 1'b0;
    restore_tgt_invalid = 1'b0;
    for (int i = 0; i < NWINDOWS; i++) begin
      if (save_tgt == 3'(i))    save_tgt_invalid    = wim[i];
      if (restore_tgt == 3'(i)) restore_tgt_invalid = wim[i];
    end
  end

  assign overflow  = save_only & save_tgt_invalid;
  assign underflow = restore_only & restore_tgt_invalid;

  // A write accompanying a legal window change lands in the new window.
  always_comb begin
    wr_win = cwp_q;
    if (save_only && !save_tgt_invalid) begin
      wr_win = save_tgt;
    end else if (restore_only && !restore_tgt_invalid) begin
      wr_win = restore_tgt;
    end
  end

  assign wr_ok = wr_en & ~overflow & ~underflow & (wr_addr != 5'd0);

  window_addr_map #(.NWINDOWS(NWINDOWS), .PW(PW)) u_map_a (
    .addr (ra_addr),
    .win  (cwp_q),
    .phys (ra_phys)
  );

  window_addr_map #(.NWINDOWS(NWINDOWS), .PW(PW)) u_map_b (
    .addr (rb_addr),
    .win  (cwp_q),
    .phys (rb_phys)
  );

  window_addr_map #(.NWINDOWS(NWINDOWS), .PW(PW)) u_map_w (
    .addr (wr_addr),
    .win  (wr_win),
    .phys (wr_phys)
  );

  // NOTE: the whole array is cleared on reset because software relies on
  // zeroed registers; this forces flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[wr_phys] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cwp_q         <= 3'd0;
      win_overflow  <= 1'b0;
      win_underflow <= 1'b0;
    end else begin
      win_overflow  <= overflow;
      win_underflow <= underflow;
      if (save_only && !save_tgt_invalid) begin
        cwp_q <= save_tgt;
      end else if (restore_only && !restore_tgt_invalid) begin
        cwp_q <= restore_tgt;
      end
    end
  end

  assign cwp = cwp_q;

`ifdef WRF_BYPASS_EN
  // wr_ok already excludes r0 and trapped writes, so neither is forwarded.
  always_comb begin
    ra_data = (ra_addr == 5'd0) ? '0 : regs[ra_phys];
    rb_data = (rb_addr == 5'd0) ? '0 : regs[rb_phys];
    if (wr_ok && ra_addr != 5'd0 && ra_phys == wr_phys) ra_data = wr_data;
    if (wr_ok && rb_addr != 5'd0 && rb_phys == wr_phys) rb_data = wr_data;
  end
`else
  always_comb begin
    ra_data = (ra_addr == 5'd0) ? '0 : regs[ra_phys];
    rb_data = (rb_addr == 5'd0) ? '0 : regs[rb_phys];
  end
`endif

endmodule

// File: tb/tb_window_register_file.sv
// Directed bench for window_register_file (NWINDOWS=4): reset, window overlap,
// traps, wrap-around, illegal save+restore, r0 handling and optional bypass.
module tb_window_register_file;

  localparam int NW = 4;
  localparam int W  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    ra_addr, rb_addr, wr_addr;
  logic [W-1:0]  ra_data, rb_data, wr_data;
  logic          wr_en, save, restore;
  logic [NW-1:0] wim;
  logic [2:0]    cwp;
  logic          win_overflow, win_underflow;

  int n_checks = 0;
  int n_pass   = 0;

  window_register_file #(.NWINDOWS(NW), .WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .ra_addr       (ra_addr),
    .rb_addr       (rb_addr),
    .ra_data       (ra_data),
    .rb_data       (rb_data),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .save          (save),
    .restore       (restore),
    .wim           (wim),
    .cwp           (cwp),
    .win_overflow  (win_overflow),
    .win_underflow (win_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one edge, then drop all one-shot controls.
  task automatic step();
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    save    = 1'b0;
    restore = 1'b0;
  endtask

  task automatic read_a(input logic [4:0] a, input string tag, input logic [31:0] exp);
    ra_addr = a;
    #1;
    check(tag, ra_data, exp);
  endtask

  task automatic read_b(input logic [4:0] a, input string tag, input logic [31:0] exp);
    rb_addr = a;
    #1;
    check(tag, rb_data, exp);
  endtask

  task automatic set_write(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  initial begin
    rst = 1'b1; ra_addr = '0; rb_addr = '0; wr_addr = '0; wr_data = '0;
    wr_en = 1'b0; save = 1'b0; restore = 1'b0; wim = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_cwp", 32'(cwp), 32'd0);
    check("rst_ovf", 32'(win_overflow), 32'd0);
    check("rst_unf", 32'(win_underflow), 32'd0);
    for (int r = 0; r < 32; r++) read_a(5'(r), $sformatf("rst_r%0d", r), 32'd0);

    // Window overlap: r8 of window 0 appears as r24 of window 3
    set_write(5'd8, 32'hAAAA_0001);
    step();
    read_a(5'd8, "w0_r8", 32'hAAAA_0001);
    save = 1'b1;
    step();
    check("save_cwp", 32'(cwp), 32'd3);
    read_a(5'd24, "w3_r24_alias", 32'hAAAA_0001);
    read_b(5'd8, "w3_r8_fresh", 32'd0);

    // Overflow: SAVE into window 2 marked invalid, write suppressed
    wim = 4'b0100;
    save = 1'b1;
    set_write(5'd16, 32'h0000_1234);
    step();
    check("ovf_cwp", 32'(cwp), 32'd3);
    check("ovf_pulse", 32'(win_overflow), 32'd1);
    check("ovf_no_unf", 32'(win_underflow), 32'd0);
    read_a(5'd16, "ovf_write_dropped", 32'd0);
    step();
    check("ovf_pulse_end", 32'(win_overflow), 32'd0);

    // Underflow: RESTORE into window 0 marked invalid
    wim = 4'b0001;
    restore = 1'b1;
    step();
    check("unf_cwp", 32'(cwp), 32'd3);
    check("unf_pulse", 32'(win_underflow), 32'd1);
    step();
    check("unf_pulse_end", 32'(win_underflow), 32'd0);

    // Wrap-around RESTORE 3 -> 0
    wim = '0;
    restore = 1'b1;
    step();
    check("wrap_cwp", 32'(cwp), 32'd0);
    read_a(5'd8, "wrap_w0_r8", 32'hAAAA_0001);

    // Illegal save+restore: no window change, write uses current window
    save = 1'b1;
    restore = 1'b1;
    set_write(5'd17, 32'h0000_0055);
    step();
    check("both_cwp", 32'(cwp), 32'd0);
    check("both_ovf", 32'(win_overflow), 32'd0);
    check("both_unf", 32'(win_underflow), 32'd0);
    read_a(5'd17, "both_r17", 32'h0000_0055);

    // r0 writes are discarded
    set_write(5'd0, 32'hFFFF_FFFF);
    step();
    read_a(5'd0, "r0_zero", 32'd0);

    // Write during SAVE lands in the new window
    save = 1'b1;
    set_write(5'd9, 32'h0000_0099);
    step();
    check("savewr_cwp", 32'(cwp), 32'd3);
    read_a(5'd9, "savewr_w3_r9", 32'h0000_0099);
    restore = 1'b1;
    step();
    read_a(5'd9, "savewr_w0_r9", 32'd0);
    read_b(5'd25, "w0_r25_is_w1_r9", 32'd0);

    // Same-cycle write/read of r3
    set_write(5'd3, 32'hDEAD_BEEF);
    ra_addr = 5'd3;
    #1;
`ifdef WRF_BYPASS_EN
    check("bypass_same_cycle", ra_data, 32'hDEAD_BEEF);
`else
    check("nobypass_same_cycle", ra_data, 32'd0);
`endif
    step();
    read_a(5'd3, "r3_next_cycle", 32'hDEAD_BEEF);

    // Reset wins over a concurrent overflow and write
    wim = 4'b1000;
    save = 1'b1;
    set_write(5'd10, 32'h0BAD_0BAD);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_cwp", 32'(cwp), 32'd0);
    check("rst2_ovf", 32'(win_overflow), 32'd0);
    read_a(5'd8, "rst2_r8", 32'd0);
    read_b(5'd3, "rst2_r3", 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
